// File: rtl/sys_pio_pkg.sv
// Shared definitions for the system PIO blocks: word addresses and status bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sys_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
  localparam logic [2:0] PIO_ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] PIO_ADDR_PULSE    = 3'd6;
  localparam logic [2:0] PIO_ADDR_STATUS   = 3'd7;

  localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/sys_pio_pulse_timer.sv
// One-shot pulse down-counter: busy for exactly PULSE_CYCLES cycles after load.
// Latency: load/cancel take effect at the next clk edge.
// Backpressure: none; load restarts the count, cancel ends it at once.
module sys_pio_pulse_timer #(
  parameter int PULSE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic cancel,
  output logic busy,
  output logic expire
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cancel) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(PULSE_CYCLES);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy   = (cnt != '0);
  // Final busy cycle: the owner of the pulse mask clears it on this edge.
  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/sys_pio_out.sv
// Avalon-MM output PIO: data register with atomic set/clear plus a timed pulse mask onto out_port.
// Latency: writes visible on out_port next cycle; readdata registered, 1-cycle read latency.
// Backpressure: none (no waitrequest); every access completes in zero wait states.
module sys_pio_out
  import sys_pio_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] pulse_mask;
  logic             pulse_wr;
  logic             pulse_load;
  logic             pulse_cancel;
  logic             busy;
  logic             expire;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr  = chipselect & ~write_n;
  assign wd  = writedata[WIDTH-1:0];
  // writedata bits above WIDTH are intentionally ignored.
  assign unused_wd = ^writedata;

  assign pulse_wr     = wr && (address == PIO_ADDR_PULSE);
  assign pulse_load   = pulse_wr && (wd != '0);
  assign pulse_cancel = pulse_wr && (wd == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        PIO_ADDR_DATA:     data_reg <= wd;
        PIO_ADDR_OUTSET:   data_reg <= data_reg | wd;
        PIO_ADDR_OUTCLEAR: data_reg <= data_reg & ~wd;
        default:           data_reg <= data_reg;
      endcase
    end
  end

  // A new PULSE write replaces the mask even on the expiring cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_mask <= '0;
    end else if (pulse_wr) begin
      pulse_mask <= wd;
    end else if (expire) begin
      pulse_mask <= '0;
    end
  end

  sys_pio_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_pulse_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (pulse_load),
    .cancel (pulse_cancel),
    .busy   (busy),
    .expire (expire)
  );

  assign out_port = data_reg | (busy ? pulse_mask : '0);

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:   rd_mux[WIDTH-1:0] = data_reg;
      PIO_ADDR_PULSE:  rd_mux[WIDTH-1:0] = pulse_mask;
      PIO_ADDR_STATUS: rd_mux[STATUS_BUSY_BIT] = busy;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sys_pio_out.sv
// Directed self-checking bench for sys_pio_out (WIDTH=8, RESET_VALUE=8'hA5, PULSE_CYCLES=4).
module tb_sys_pio_out;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int failures = 0;

  sys_pio_out #(
    .WIDTH        (8),
    .RESET_VALUE  (8'hA5),
    .PULSE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  logic [31:0] rv;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_out", {24'd0, out_port}, 32'h0000_00A5);
    chk("rst_rd", readdata, 32'h0);
    reset = 1'b0;
    tick();

    // 1. Read DATA after reset
    bus_rd(3'd0, rv);
    chk("rd_data_rst", rv, 32'h0000_00A5);
    chk("out_rst", {24'd0, out_port}, 32'h0000_00A5);

    // 2. DATA write, upper writedata bits ignored
    bus_wr(3'd0, 32'h0000_0F3C);
    chk("out_data", {24'd0, out_port}, 32'h0000_003C);
    bus_rd(3'd0, rv);
    chk("rd_data", rv, 32'h0000_003C);

    // 3. OUTSET / OUTCLEAR, write-only and unused addresses read 0
    bus_wr(3'd4, 32'h0000_0081);
    chk("out_set", {24'd0, out_port}, 32'h0000_00BD);
    bus_wr(3'd5, 32'h0000_000C);
    chk("out_clr", {24'd0, out_port}, 32'h0000_00B1);
    bus_rd(3'd4, rv);
    chk("rd_outset", rv, 32'h0);
    bus_rd(3'd5, rv);
    chk("rd_outclr", rv, 32'h0);
    bus_wr(3'd2, 32'h0000_00FF);
    chk("wr_unused", {24'd0, out_port}, 32'h0000_00B1);
    bus_rd(3'd1, rv);
    chk("rd_unused", rv, 32'h0);

    // 4. Pulse lasts exactly 4 cycles
    bus_wr(3'd0, 32'h0);
    chk("out_zero", {24'd0, out_port}, 32'h0);
    bus_wr(3'd6, 32'h0000_0010);
    chk("pulse_c1", {24'd0, out_port}, 32'h0000_0010);
    tick();
    chk("pulse_c2", {24'd0, out_port}, 32'h0000_0010);
    tick();
    chk("pulse_c3", {24'd0, out_port}, 32'h0000_0010);
    tick();
    chk("pulse_c4", {24'd0, out_port}, 32'h0000_0010);
    tick();
    chk("pulse_end", {24'd0, out_port}, 32'h0);
    bus_rd(3'd7, rv);
    chk("status_idle", rv, 32'h0);
    bus_rd(3'd6, rv);
    chk("rd_mask_done", rv, 32'h0);

    // 4b. STATUS while busy, OUTSET mid-pulse
    bus_wr(3'd6, 32'h0000_0010);
    bus_rd(3'd7, rv);
    chk("status_busy", rv, 32'h1);
    bus_rd(3'd6, rv);
    chk("rd_mask", rv, 32'h0000_0010);
    bus_wr(3'd4, 32'h0000_0001);
    chk("set_mid_pulse", {24'd0, out_port}, 32'h0000_0011);
    tick();
    chk("set_after_pulse", {24'd0, out_port}, 32'h0000_0001);
    bus_rd(3'd7, rv);
    chk("status_after", rv, 32'h0);

    // 5. Restart replaces mask; PULSE 0 cancels
    bus_wr(3'd5, 32'h0000_0001);
    chk("clr_bit0", {24'd0, out_port}, 32'h0);
    bus_wr(3'd6, 32'h0000_0002);
    chk("p2_c1", {24'd0, out_port}, 32'h0000_0002);
    tick();
    chk("p2_c2", {24'd0, out_port}, 32'h0000_0002);
    bus_wr(3'd6, 32'h0000_0004);
    chk("p4_c1", {24'd0, out_port}, 32'h0000_0004);
    tick();
    chk("p4_c2", {24'd0, out_port}, 32'h0000_0004);
    tick();
    chk("p4_c3", {24'd0, out_port}, 32'h0000_0004);
    tick();
    chk("p4_c4", {24'd0, out_port}, 32'h0000_0004);
    tick();
    chk("p4_end", {24'd0, out_port}, 32'h0);
    bus_wr(3'd6, 32'h0000_0008);
    chk("p8_c1", {24'd0, out_port}, 32'h0000_0008);
    bus_wr(3'd6, 32'h0);
    chk("cancel_out", {24'd0, out_port}, 32'h0);
    bus_rd(3'd7, rv);
    chk("cancel_status", rv, 32'h0);

    // 6. Async reset mid-pulse
    bus_wr(3'd0, 32'h0000_00FF);
    bus_wr(3'd6, 32'h0000_0010);
    chk("pre_reset", {24'd0, out_port}, 32'h0000_00FF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out", {24'd0, out_port}, 32'h0000_00A5);
    chk("async_rst_rd", readdata, 32'h0);
    tick();
    #2;
    reset = 1'b0;
    bus_rd(3'd7, rv);
    chk("status_post_rst", rv, 32'h0);
    chk("out_post_rst", {24'd0, out_port}, 32'h0000_00A5);
    bus_rd(3'd6, rv);
    chk("mask_post_rst", rv, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
